// File: rtl/sel_gen.sv
// sel_gen: round-robin source-select generator for the fitter input stage.
// Watches up to eight event sources and grants one at a time. The select code
// stays stable until the granted source ends its event. A fixed two-cycle gap
// between events lets the downstream delayed select settle.
// Optional watchdog: define SEL_GEN_TIMEOUT_EN to compile in the BUSY idle
// counter, the HOLD_MAX compare and the TIMEOUT pulse. Without the macro, BUSY
// waits for DV&EE indefinitely and TIMEOUT is tied low.
module sel_gen #(
  parameter int NSRC     = 8,
  parameter int HOLD_MAX = 255
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic [NSRC-1:0] REQ,
  input  logic            DV,
  input  logic            EE,
  input  logic            HALT,
  output logic [2:0]      OUT,
  output logic            VALID,
  output logic [NSRC-1:0] GRANT,
  output logic            TIMEOUT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // After reset the scan starts one past LAST, so source 0 wins first.
  localparam logic [2:0] LAST_RST = 3'(NSRC - 1);

  // Elaboration-time guards on the legal parameter ranges.
  if (NSRC < 1 || NSRC > 8) begin : g_bad_nsrc
    $error("sel_gen: NSRC must be in 1..8");
  end
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("sel_gen: HOLD_MAX must be in 1..255");
  end

  logic [1:0]      state_q, state_d;
  logic [2:0]      last_q, last_d;
  logic [2:0]      out_q, out_d;
  logic            valid_q, valid_d;
  logic [NSRC-1:0] grant_q, grant_d;
  logic            gcnt_q, gcnt_d;

`ifdef SEL_GEN_TIMEOUT_EN
  // Fires on the no-DV edge that would bring WCNT up to HOLD_MAX.
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

  logic [7:0] wcnt_q, wcnt_d;
  logic       timeout_q, timeout_d;
`endif

  logic [7:0] req_pad;
  logic [2:0] cand;
  logic       arb_hit;
  logic [2:0] arb_idx;

  // Round-robin scan: LAST+1, LAST+2, ... modulo NSRC, first requester wins.
  // The loop runs from the far end so the nearest hit is written last.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    req_pad = 8'(REQ);
    cand    = '0;
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int k = NSRC; k >= 1; k--) begin
      cand = 3'((int'(last_q) + k) % NSRC);
      if (req_pad[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  // Next-state logic: IDLE arbitrates, BUSY waits for end of event (or the
  // watchdog), GAP holds VALID low for two cycles and then arbitrates.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    out_d   = out_q;
    valid_d = valid_q;
    grant_d = grant_q;
    gcnt_d  = gcnt_q;
`ifdef SEL_GEN_TIMEOUT_EN
    wcnt_d    = wcnt_q;
    timeout_d = 1'b0;
`endif

    if (!HALT) begin
      unique case (state_q)
        S_BUSY: begin
          if (DV && EE) begin
            state_d = S_GAP;
            valid_d = 1'b0;
            grant_d = '0;
            gcnt_d  = 1'b1;
`ifdef SEL_GEN_TIMEOUT_EN
            wcnt_d  = '0;
`endif
          end
`ifdef SEL_GEN_TIMEOUT_EN
          else if (DV) begin
            wcnt_d = '0;
          end else if (wcnt_q == HOLD_LIM) begin
            // Abort the stuck event; LAST already points at it, so it loses its turn.
            state_d   = S_GAP;
            valid_d   = 1'b0;
            grant_d   = '0;
            gcnt_d    = 1'b1;
            wcnt_d    = '0;
            timeout_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
`endif
        end

        S_GAP: begin
          if (gcnt_q) begin
            gcnt_d = 1'b0;
          end else if (arb_hit) begin
            state_d = S_BUSY;
            last_d  = arb_idx;
            out_d   = arb_idx;
            valid_d = 1'b1;
            grant_d = NSRC'(8'b1 << arb_idx);
`ifdef SEL_GEN_TIMEOUT_EN
            wcnt_d  = '0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end

        default: begin
          // IDLE, plus recovery from the unused encoding.
          state_d = S_IDLE;
          valid_d = 1'b0;
          grant_d = '0;
          if (arb_hit) begin
            state_d = S_BUSY;
            last_d  = arb_idx;
            out_d   = arb_idx;
            valid_d = 1'b1;
            grant_d = NSRC'(8'b1 << arb_idx);
`ifdef SEL_GEN_TIMEOUT_EN
            wcnt_d  = '0;
`endif
          end
        end
      endcase
    end
  end

  // Main state and output registers with synchronous reset.
  always_ff @(posedge CLOCK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RESET) begin
      state_q <= S_IDLE;
      last_q  <= LAST_RST;
      out_q   <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      gcnt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      gcnt_q  <= gcnt_d;
    end
  end

`ifdef SEL_GEN_TIMEOUT_EN
  // Watchdog counter and one-cycle abort pulse.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  assign TIMEOUT = 1'b0;
`endif

  assign OUT   = out_q;
  assign VALID = valid_q;
  assign GRANT = grant_q;

endmodule
